// File: rtl/multicycle_control_fsm.sv
// Multicycle control unit for the single-bus MIPS-subset CPU.
// Explicit state register; all datapath controls decoded combinationally from state and IR fields.
module multicycle_control_fsm #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit BEQ_EN        = 1'b1,
  parameter int ALUCTLW       = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_we,
  output logic               ir_we,
  output logic               mem_we,
  output logic               reg_we,
  output logic               iord,
  output logic [1:0]         pc_src,
  output logic               alu_src_a,
  output logic [2:0]         alu_src_b,
  output logic [1:0]         reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic [ALUCTLW-1:0] alu_ctl,
  output logic [2:0]         state,
  output logic               instr_done,
  output logic               illegal
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd7
  } state_t;

  localparam logic [ALUCTLW-1:0] ALU_ADD = ALUCTLW'(0);
  localparam logic [ALUCTLW-1:0] ALU_SUB = ALUCTLW'(1);
  localparam logic [ALUCTLW-1:0] ALU_XOR = ALUCTLW'(2);
  localparam logic [ALUCTLW-1:0] ALU_SLT = ALUCTLW'(3);

  state_t cur, nxt;

  logic is_r, r_ok, is_jr, is_j, is_jal, is_lw, is_sw, is_addi, is_xori, is_bne, is_beq;
  logic to_exec, rdy;
  logic [ALUCTLW-1:0] r_ctl;

  assign is_r    = (opcode == 6'h00);
  assign is_jr   = is_r && (funct == 6'h08);
  assign r_ok    = is_r && (funct == 6'h20 || funct == 6'h22 || funct == 6'h2A);
  assign is_j    = (opcode == 6'h02);
  assign is_jal  = (opcode == 6'h03);
  assign is_lw   = (opcode == 6'h23);
  assign is_sw   = (opcode == 6'h2B);
  assign is_addi = (opcode == 6'h08);
  assign is_xori = (opcode == 6'h0E);
  assign is_bne  = (opcode == 6'h05);
  assign is_beq  = BEQ_EN && (opcode == 6'h04);
  assign to_exec = is_lw || is_sw || is_addi || is_xori || is_bne || is_beq || r_ok;
  // Without the handshake every memory access is treated as completing in one cycle.
  assign rdy     = !MEM_HANDSHAKE || mem_ready;
  assign r_ctl   = (funct == 6'h22) ? ALU_SUB : (funct == 6'h2A) ? ALU_SLT : ALU_ADD;
  assign state   = cur;

  always_comb begin
    nxt        = cur;
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    mem_we     = 1'b0;
    reg_we     = 1'b0;
    iord       = 1'b0;
    pc_src     = 2'd0;
    alu_src_a  = 1'b0;
    alu_src_b  = 3'd0;
    reg_dst    = 2'd0;
    mem_to_reg = 2'd0;
    alu_ctl    = ALU_ADD;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (cur)
      FETCH: begin
        alu_src_b = 3'd1;
        if (rdy) begin
          ir_we = 1'b1;
          pc_we = 1'b1;
          nxt   = DECODE;
        end
      end
      DECODE: begin
        // Branch target is precomputed into ALUOut while the opcode is decoded.
        alu_src_b = 3'd4;
        if (is_j || is_jal) begin
          pc_we      = 1'b1;
          pc_src     = 2'd2;
          instr_done = 1'b1;
          nxt        = FETCH;
          if (is_jal) begin
            reg_we     = 1'b1;
            reg_dst    = 2'd2;
            mem_to_reg = 2'd2;
          end
        end else if (is_jr) begin
          pc_we      = 1'b1;
          pc_src     = 2'd3;
          instr_done = 1'b1;
          nxt        = FETCH;
        end else if (to_exec) begin
          nxt = EXEC;
        end else begin
          nxt = TRAP;
        end
      end
      EXEC: begin
        alu_src_a = 1'b1;
        if (is_lw || is_sw) begin
          alu_src_b = 3'd2;
          nxt       = MEM;
        end else if (r_ok) begin
          alu_ctl = r_ctl;
          nxt     = WB;
        end else if (is_addi) begin
          alu_src_b = 3'd2;
          nxt       = WB;
        end else if (is_xori) begin
          alu_src_b = 3'd3;
          alu_ctl   = ALU_XOR;
          nxt       = WB;
        end else if (is_bne || is_beq) begin
          alu_ctl    = ALU_SUB;
          pc_src     = 2'd1;
          pc_we      = is_bne ? !zero : zero;
          instr_done = 1'b1;
          nxt        = FETCH;
        end else begin
          nxt = TRAP;
        end
      end
      MEM: begin
        iord = 1'b1;
        if (is_sw) begin
          mem_we = 1'b1;
          if (rdy) begin
            instr_done = 1'b1;
            nxt        = FETCH;
          end
        end else if (is_lw) begin
          if (rdy) nxt = WB;
        end else begin
          nxt = TRAP;
        end
      end
      WB: begin
        reg_we     = 1'b1;
        instr_done = 1'b1;
        nxt        = FETCH;
        if (is_lw) mem_to_reg = 2'd1;
        else if (r_ok) reg_dst = 2'd1;
      end
      TRAP: illegal = 1'b1;
      default: nxt = TRAP;
    endcase
    // Reset silences every strobe and select so an abandoned instruction writes nothing.
    if (reset) begin
      pc_we      = 1'b0;
      ir_we      = 1'b0;
      mem_we     = 1'b0;
      reg_we     = 1'b0;
      iord       = 1'b0;
      pc_src     = 2'd0;
      alu_src_a  = 1'b0;
      alu_src_b  = 3'd0;
      reg_dst    = 2'd0;
      mem_to_reg = 2'd0;
      alu_ctl    = ALU_ADD;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cur <= FETCH;
    else       cur <= nxt;
  end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

- Parametrised multicycle control unit for the single-bus MIPS-subset CPU.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives every mux select, write enable and ALU control in the datapath.
- Generalises the per-instruction counter scheme with an explicit state register and an optional memory-ready handshake.
- Adds BEQ, illegal-opcode trapping and an instruction-retire strobe.

## Interface
- `MEM_HANDSHAKE`, default 1: 1 makes FETCH/MEM wait for `mem_ready`; 0 ignores `mem_ready`.
- `BEQ_EN`, default 1: 1 decodes BEQ (opcode 0x04); 0 treats it as illegal.
- `ALUCTLW`, default 3: width of `alu_ctl`.
- ALU codes: ADD=0, SUB=1, XOR=2, SLT=3.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `opcode` in 6: IR[31:26]; valid from DECODE onward.
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU zero flag, combinational in the same cycle.
- `mem_ready` in 1: memory access completes this cycle.
- `pc_we` out 1: PC write.
- `ir_we` out 1: IR load.
- `mem_we` out 1: data memory write.
- `reg_we` out 1: register file write.
- `iord` out 1: memory address source. 0=PC, 1=ALUOut.
- `pc_src` out 2: 0=ALU result, 1=ALUOut, 2=jump target, 3=reg A.
- `alu_src_a` out 1: 0=PC, 1=reg A.
- `alu_src_b` out 3: 0=reg B, 1=const 4, 2=sext imm, 3=zext imm, 4=sext imm<<2.
- `reg_dst` out 2: 0=rt, 1=rd, 2=r31.
- `mem_to_reg` out 2: 0=ALUOut, 1=memory data, 2=PC.
- `alu_ctl` out ALUCTLW: ALU operation.
- `state` out 3: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- `instr_done` out 1: one-cycle pulse on the final cycle of each instruction.
- `illegal` out 1: high while in TRAP.

## Operation
- Outputs are combinational from `state`, `opcode`, `funct` and `zero`. Unlisted strobes are 0; unlisted selects are 0.
- FETCH:
  - Drive iord=0, alu_src_a=0, alu_src_b=1, alu_ctl=ADD, pc_src=0.
  - ir_we and pc_we are asserted only when `mem_ready` (or MEM_HANDSHAKE=0); otherwise stay in FETCH.
  - Next state: DECODE.
- DECODE:
  - Drive alu_src_a=0, alu_src_b=4, alu_ctl=ADD (branch target into ALUOut).
  - J (0x02): pc_we, pc_src=2 -> FETCH.
  - JAL (0x03): pc_we, pc_src=2, reg_we, reg_dst=2, mem_to_reg=2 -> FETCH.
  - JR (opcode 0x00, funct 0x08): pc_we, pc_src=3 -> FETCH.
  - LW 0x23, SW 0x2B, ADDI 0x08, XORI 0x0E, BNE 0x05, BEQ 0x04, and R-type funct ADD 0x20 / SUB 0x22 / SLT 0x2A -> EXEC.
  - Anything else -> TRAP.
- EXEC:
  - LW/SW: alu_src_a=1, alu_src_b=2, ADD -> MEM.
  - R-type: alu_src_a=1, alu_src_b=0, alu_ctl from funct -> WB.
  - ADDI: alu_src_a=1, alu_src_b=2, ADD -> WB.
  - XORI: alu_src_a=1, alu_src_b=3, XOR -> WB.
  - BNE/BEQ: alu_src_a=1, alu_src_b=0, SUB, pc_src=1; pc_we = ~zero for BNE, zero for BEQ -> FETCH.
- MEM:
  - Drive iord=1.
  - SW: mem_we held until `mem_ready`, then -> FETCH.
  - LW: wait for `mem_ready`, then -> WB.
- WB:
  - Drive reg_we=1.
  - LW: reg_dst=0, mem_to_reg=1.
  - R-type: reg_dst=1, mem_to_reg=0.
  - ADDI/XORI: reg_dst=0, mem_to_reg=0.
  - Next state: FETCH.
- TRAP: all strobes 0, illegal=1. Stays in TRAP until `reset`.

## Timing
- Reset behaviour:
  - Reset asserted at an edge gives state=FETCH on the next cycle.
  - While `reset` is high, every strobe (pc_we, ir_we, mem_we, reg_we, instr_done) is forced to 0.
  - Selects are 0 during reset; illegal=0.
  - Reset mid-instruction abandons it with no partial writes after the reset edge.
- Latency with zero wait cycles:
  - J/JR/JAL: 2 cycles.
  - BNE/BEQ: 3 cycles.
  - R-type/ADDI/XORI/SW: 4 cycles.
  - LW: 5 cycles.
- Each cycle `mem_ready` is low in FETCH or MEM adds one cycle, with outputs held.
- `instr_done` is asserted together with the cycle whose next state is FETCH:
  - DECODE for jumps.
  - EXEC for branches.
  - MEM for SW.
  - WB otherwise.
- `instr_done` is not asserted in a stalled cycle.
- A branch decision uses `zero` in the EXEC cycle only.
- With MEM_HANDSHAKE=0, memory is single-cycle and `mem_ready` changes nothing.

## Test plan
- Reset, then LW with `mem_ready`=1 -> states 0,1,2,3,4,0. In WB: reg_we=1, reg_dst=0, mem_to_reg=1. instr_done pulses once, in WB.
- SW with `mem_ready` low for 2 cycles in MEM -> mem_we held high for 3 cycles, iord=1, then FETCH. Total 6 cycles.
- BNE with zero=1 -> EXEC pc_we=0. BNE with zero=0 -> pc_we=1, pc_src=1. BEQ inverts both. With BEQ_EN=0, opcode 0x04 -> TRAP.
- JAL -> DECODE: pc_we=1, pc_src=2, reg_we=1, reg_dst=2, mem_to_reg=2. Returns to FETCH after 2 cycles.
- R-type SLT then XORI -> EXEC alu_ctl=3 with alu_src_b=0, then alu_ctl=2 with alu_src_b=3. Both WB reg_we=1.
- Opcode 0x3F -> TRAP; illegal=1 held 10 cycles. Reset pulse -> state=FETCH, illegal=0.
